// File: rtl/vsi_pkt_reader.sv
// vsi_pkt_reader: sweeps each packet's addresses into a fixed-latency read slave, splits the
// returned bytes into a 16-bit header and a payload stream, and checks header continuity.
module vsi_pkt_reader #(
  parameter int unsigned PKT_LEN    = 256,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned HDR_STEP   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cont,
  output logic        ram_rd_rq,
  output logic [15:0] rd_addr,
  input  logic [7:0]  data_i,
  output logic [7:0]  pl_data,
  output logic        pl_valid,
  output logic [15:0] pl_idx,
  output logic [15:0] hdr,
  output logic        hdr_valid,
  output logic        seq_err,
  input  logic        err_clr,
  output logic        busy,
  output logic        done,
  output logic [15:0] pkt_cnt
);

  localparam int unsigned   AW        = 16;
  localparam logic [AW-1:0] LAST_ADDR = AW'(PKT_LEN - 1);
  localparam logic [AW-1:0] STEP      = AW'(HDR_STEP);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t        state, state_d;
  logic          rq_d, done_d, busy_d;
  logic [AW-1:0] addr_d;

  logic [RD_LATENCY-1:0]         tag_v;
  logic [RD_LATENCY-1:0][AW-1:0] tag_a;
  logic                          tail_v_c;
  logic [AW-1:0]                 tail_a_c;

  logic          first_pkt;
  logic [AW-1:0] last_hdr;
  logic [AW-1:0] hdr_full_c;
  logic          seq_set_c;

  assign tail_v_c   = tag_v[RD_LATENCY-1];
  assign tail_a_c   = tag_a[RD_LATENCY-1];
  assign hdr_full_c = {hdr[15:8], data_i};
  assign seq_set_c  = tail_v_c && (tail_a_c == AW'(1)) && !first_pkt &&
                      (hdr_full_c != last_hdr + STEP);

  // Next-state and next-output logic for the read sequencer
  always_comb begin
    state_d = state;
    rq_d    = 1'b0;
    addr_d  = '0;
    done_d  = 1'b0;
    busy_d  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          rq_d    = 1'b1;
        end
      end
      S_ISSUE: begin
        if (rd_addr == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          rq_d   = 1'b1;
          addr_d = rd_addr + AW'(1);
        end
      end
      S_DRAIN: begin
        // The last issued address reaching the tail means the pipeline is empty after this cycle
        if (tail_v_c && (tail_a_c == LAST_ADDR)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        if (cont) begin
          state_d = S_ISSUE;
          rq_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Sequencer state and its registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ram_rd_rq <= 1'b0;
      rd_addr   <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      state     <= state_d;
      ram_rd_rq <= rq_d;
      rd_addr   <= addr_d;
      done      <= done_d;
      busy      <= busy_d;
      pkt_cnt   <= pkt_cnt + AW'(done_d);
    end
  end

  // Tag pipeline, return decoding and header sequence check
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v     <= '0;
      tag_a     <= '0;
      pl_data   <= '0;
      pl_valid  <= 1'b0;
      pl_idx    <= '0;
      hdr       <= '0;
      hdr_valid <= 1'b0;
      seq_err   <= 1'b0;
      first_pkt <= 1'b1;
      last_hdr  <= '0;
    end else begin
      tag_v[0] <= ram_rd_rq;
      tag_a[0] <= rd_addr;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_a[i] <= tag_a[i-1];
      end
      pl_valid  <= 1'b0;
      hdr_valid <= 1'b0;
      if (tail_v_c) begin
        if (tail_a_c == '0) begin
          hdr[15:8] <= data_i;
        end else if (tail_a_c == AW'(1)) begin
          hdr[7:0]  <= data_i;
          hdr_valid <= 1'b1;
          first_pkt <= 1'b0;
          last_hdr  <= hdr_full_c;
        end else begin
          pl_data  <= data_i;
          pl_valid <= 1'b1;
          pl_idx   <= tail_a_c - AW'(2);
        end
      end
      // A new error outranks a simultaneous clear
      seq_err <= (seq_err & ~err_clr) | seq_set_c;
    end
  end

endmodule

// File: tb/tb_vsi_pkt_reader.sv
// tb_vsi_pkt_reader: random and directed packets against a scoreboard fed by a header/payload
// reference model; a second instance covers a longer read latency.
module tb_vsi_pkt_reader;

  localparam int unsigned PKT_LEN = 8;
  localparam int unsigned LAT     = 2;
  localparam int unsigned LAT4    = 4;
  localparam int unsigned NPL     = PKT_LEN - 2;
  localparam int unsigned MAXP    = 64;
  localparam int          BUDGET  = 200;

  typedef struct packed { logic [15:0] idx; logic [7:0] data; } pl_t;
  typedef struct packed { logic [15:0] h; logic err; } hd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, cont = 1'b0, err_clr = 1'b0;
  logic        ram_rd_rq, pl_valid, hdr_valid, seq_err, busy, done;
  logic [15:0] rd_addr, pl_idx, hdr, pkt_cnt;
  logic [7:0]  data_i, pl_data;

  logic        start4 = 1'b0;
  logic        rq4, pl_valid4, hdr_valid4, seq_err4, busy4, done4;
  logic [15:0] addr4, pl_idx4, hdr4, pkt_cnt4;
  logic [7:0]  data4, pl_data4;

  vsi_pkt_reader #(.PKT_LEN(PKT_LEN), .RD_LATENCY(LAT), .HDR_STEP(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .ram_rd_rq(ram_rd_rq), .rd_addr(rd_addr),
    .data_i(data_i), .pl_data(pl_data), .pl_valid(pl_valid), .pl_idx(pl_idx), .hdr(hdr),
    .hdr_valid(hdr_valid), .seq_err(seq_err), .err_clr(err_clr), .busy(busy), .done(done),
    .pkt_cnt(pkt_cnt));

  vsi_pkt_reader #(.PKT_LEN(PKT_LEN), .RD_LATENCY(LAT4), .HDR_STEP(1)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .cont(1'b0), .ram_rd_rq(rq4), .rd_addr(addr4),
    .data_i(data4), .pl_data(pl_data4), .pl_valid(pl_valid4), .pl_idx(pl_idx4), .hdr(hdr4),
    .hdr_valid(hdr_valid4), .seq_err(seq_err4), .err_clr(1'b0), .busy(busy4), .done(done4),
    .pkt_cnt(pkt_cnt4));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Slave model: per-packet byte images, returned LAT cycles after the address
  logic [7:0]  pkt_mem [MAXP][PKT_LEN];
  int          sp = 0;
  logic [15:0] dl_a [LAT] = '{default: '0};
  int          dl_p [LAT] = '{default: 0};
  always @(posedge clk) begin
    for (int i = int'(LAT) - 1; i > 0; i--) begin
      dl_a[i] <= dl_a[i-1];
      dl_p[i] <= dl_p[i-1];
    end
    dl_a[0] <= rd_addr;
    if (ram_rd_rq && rd_addr == 16'd0) begin
      dl_p[0] <= sp;
      sp      <= sp + 1;
    end else begin
      dl_p[0] <= sp - 1;
    end
  end
  always_comb data_i = pkt_mem[(dl_p[LAT-1] < 0 ? 0 : dl_p[LAT-1]) % MAXP][dl_a[LAT-1] % PKT_LEN];

  logic [15:0] dl4 [LAT4] = '{default: '0};
  always @(posedge clk) begin
    for (int i = int'(LAT4) - 1; i > 0; i--) dl4[i] <= dl4[i-1];
    dl4[0] <= addr4;
  end
  assign data4 = dl4[LAT4-1][7:0] ^ 8'h5A;

  // Reference model and scoreboard queues
  pl_t         exp_pl[$];
  hd_t         exp_hd[$];
  logic [15:0] exp_dn[$];
  bit          m_first = 1'b1, m_err = 1'b0;
  logic [15:0] m_last = '0, m_cnt = '0;
  int          gen_n = 0;

  task automatic issue_pkt(input logic [15:0] h, input bit fixed);
    int g;
    logic [7:0] b;
    g = gen_n % MAXP;
    pkt_mem[g][0] = h[15:8];
    pkt_mem[g][1] = h[7:0];
    for (int i = 0; i < int'(NPL); i++) begin
      b = fixed ? 8'(8'hA0 + i) : 8'($urandom);
      pkt_mem[g][i+2] = b;
      exp_pl.push_back('{idx: 16'(i), data: b});
    end
    if (!m_first && h != 16'(m_last + 16'd1)) m_err = 1'b1;
    m_first = 1'b0;
    m_last  = h;
    exp_hd.push_back('{h: h, err: m_err});
    m_cnt = m_cnt + 16'd1;
    exp_dn.push_back(m_cnt);
    gen_n++;
  endtask

  task automatic model_reset();
    exp_pl.delete();
    exp_hd.delete();
    exp_dn.delete();
    m_first = 1'b1;
    m_err   = 1'b0;
    m_cnt   = '0;
  endtask

  // Monitor: pops expectations whenever the DUT strobes, plus issue-side checks
  int          cyc = 0;
  int          t_last = 0, t2 = 0, t2_4 = 0, done_cnt = 0, rq_cyc = 0, hv4_cnt = 0;
  logic [15:0] ia = '0;
  bit          b2b = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) b2b = 1'b0;
    else if (done && cont) b2b = 1'b1;
  end

  always @(negedge clk) begin
    pl_t p;
    hd_t q;
    logic [15:0] d;
    if (rst) begin
      ia = '0;
    end else begin
      if (ram_rd_rq) begin
        chk("rd_addr", rd_addr, ia);
        ia = 16'((ia + 16'd1) % 16'(PKT_LEN));
        rq_cyc++;
        if (rd_addr == 16'd2) t2 = cyc;
        if (rd_addr == 16'(PKT_LEN - 1)) t_last = cyc;
        if (rd_addr == 16'd0 && b2b) begin
          chk("b2b_gap", 32'(cyc - t_last), LAT + 2);
          b2b = 1'b0;
        end
      end
      if (pl_valid) begin
        if (exp_pl.size() == 0) chk("pl_unexpected", 1, 0);
        else begin
          p = exp_pl.pop_front();
          chk("pl_idx", pl_idx, p.idx);
          chk("pl_data", pl_data, p.data);
          if (pl_idx == 16'd0) chk("pl_latency", 32'(cyc - t2), LAT + 1);
        end
      end
      if (hdr_valid) begin
        if (exp_hd.size() == 0) chk("hdr_unexpected", 1, 0);
        else begin
          q = exp_hd.pop_front();
          chk("hdr", hdr, q.h);
          chk("seq_err", seq_err, q.err);
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_dn.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          d = exp_dn.pop_front();
          chk("pkt_cnt", pkt_cnt, d);
        end
      end
      if (rq4 && addr4 == 16'd2) t2_4 = cyc;
      if (hdr_valid4) hv4_cnt++;
      if (pl_valid4 && pl_idx4 == 16'd0) begin
        chk("lat4_pl_latency", 32'(cyc - t2_4), LAT4 + 1);
        chk("lat4_pl_data", pl_data4, 8'h58);
      end
    end
  end

  // Bounded waits; an expired bound counts as a failed comparison
  task automatic wait_dones(input int n);
    int c = 0;
    for (int k = 0; k < BUDGET * n; k++) begin
      @(negedge clk);
      if (done) c++;
      if (c == n) return;
    end
    chk("timeout_done", 0, 1);
  endtask

  task automatic wait_addr(input logic [15:0] a);
    for (int k = 0; k < BUDGET; k++) begin
      if (ram_rd_rq && rd_addr == a) return;
      @(negedge clk);
    end
    chk("timeout_addr", 0, 1);
  endtask

  task automatic run_pkts(input int k);
    cont  = (k > 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (k > 1) begin
      wait_dones(k - 1);
      @(negedge clk);
      cont = 1'b0;
    end
    wait_dones(1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_err   = 1'b0;
    chk("seq_err_cleared", seq_err, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rq"}, ram_rd_rq, 0);      chk({tag, "_addr"}, rd_addr, 0);
    chk({tag, "_pl_data"}, pl_data, 0);   chk({tag, "_pl_valid"}, pl_valid, 0);
    chk({tag, "_pl_idx"}, pl_idx, 0);     chk({tag, "_hdr"}, hdr, 0);
    chk({tag, "_hdr_valid"}, hdr_valid, 0); chk({tag, "_seq_err"}, seq_err, 0);
    chk({tag, "_busy"}, busy, 0);         chk({tag, "_done"}, done, 0);
    chk({tag, "_pkt_cnt"}, pkt_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, d0;
    logic [15:0] h;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_all_zero("reset");
    @(negedge clk);

    // Single packet, header 0x0005, payload 0xA0..0xA5
    rq_cyc = 0;
    issue_pkt(16'h0005, 1'b1);
    run_pkts(1);
    chk("single_rq_cycles", rq_cyc, PKT_LEN);
    chk("single_seq_err", seq_err, 0);

    // Back-to-back 0x0005, 0x0006, 0x0008 from a fresh reset
    do_reset();
    issue_pkt(16'h0005, 1'b0);
    issue_pkt(16'h0006, 1'b0);
    issue_pkt(16'h0008, 1'b0);
    run_pkts(3);
    chk("cont_pkt_cnt", pkt_cnt, 3);

    // Header wrap 0xFFFF -> 0x0000, then clear colliding with a new error
    issue_pkt(16'hFFFF, 1'b0);
    run_pkts(1);
    clear_err();
    issue_pkt(16'h0000, 1'b0);
    run_pkts(1);
    chk("wrap_seq_err", seq_err, 0);
    issue_pkt(16'h0007, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_addr(16'd1);
    repeat (LAT) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    wait_dones(1);
    repeat (2) @(negedge clk);
    chk("set_beats_clear", seq_err, 1);

    // start during ISSUE and DRAIN is ignored
    clear_err();
    rq_cyc = 0;
    d0 = done_cnt;
    issue_pkt(16'h0008, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_addr(16'd3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < BUDGET && ram_rd_rq; j++) @(negedge clk);
    chk("drain_busy", busy, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_dones(1);
    repeat (15) @(negedge clk);
    chk("ignore_rq_cycles", rq_cyc, PKT_LEN);
    chk("ignore_done_count", 32'(done_cnt - d0), 1);
    chk("ignore_busy_idle", busy, 0);

    // Reset at rd_addr 4 aborts the packet; the next packet is a first packet again
    issue_pkt(16'h0009, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_addr(16'd4);
    #2 rst = 1'b1;
    #1 chk_all_zero("midreset");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    chk("midreset_no_done", 32'(done_cnt - d0), 0);
    issue_pkt(16'h1234, 1'b0);
    run_pkts(1);
    chk("post_reset_seq_err", seq_err, 0);
    chk("post_reset_pkt_cnt", pkt_cnt, 1);

    // Random packet bursts with mostly-correct headers
    for (int it = 0; it < 6; it++) begin
      clear_err();
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) begin
        h = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(m_last + 16'd1);
        issue_pkt(h, 1'b0);
      end
      run_pkts(k);
    end

    // Longer read latency instance
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int j = 0; j < BUDGET && !done4; j++) @(negedge clk);
    chk("lat4_done", done4, 1);
    repeat (3) @(negedge clk);
    chk("lat4_hdr", hdr4, 16'h5A5B);
    chk("lat4_hdr_pulses", hv4_cnt, 1);
    chk("lat4_pkt_cnt", pkt_cnt4, 1);
    chk("lat4_seq_err", seq_err4, 0);
    chk("lat4_busy", busy4, 0);

    chk("pl_left", exp_pl.size(), 0);
    chk("hdr_left", exp_hd.size(), 0);
    chk("done_left", exp_dn.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vsi_pkt_reader.md
Name: vsi_pkt_reader

Overview:
- Initiator/reader side of the slave read interface (`ram_rd_rq`/`rd_addr`/`data_o`).
- Per packet: drives a read-address sweep 0..PKT_LEN-1 into the slave and realigns returned bytes using a fixed read latency.
- Splits each packet into the 16-bit header (addr 0 = high byte, addr 1 = low byte) and payload bytes (addr ≥ 2).
- Checks header sequence continuity and streams payload to downstream logic.

Parameters:
- PKT_LEN, 256: addresses issued per packet (header + payload); legal range 3..65535.
- RD_LATENCY, 2: cycles from `rd_addr` presented to the matching byte on `data_i`; legal range 1..8.
- HDR_STEP, 1: required header increment between consecutive packets, modulo 2^16.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request one packet; sampled only in IDLE.
- cont  in  1  continuous mode: when 1 at DONE, go straight to the next packet.
- ram_rd_rq  out  1  read request to slave.
- rd_addr  out  16  read address to slave.
- data_i  in  8  slave read data (`data_o` of slave).
- pl_data  out  8  payload byte.
- pl_valid  out  1  payload byte strobe, one cycle per byte, no backpressure.
- pl_idx  out  16  payload index, 0..PKT_LEN-3.
- hdr  out  16  captured header of the current/last packet.
- hdr_valid  out  1  one-cycle pulse when `hdr` is complete.
- seq_err  out  1  sticky header-sequence error.
- err_clr  in  1  clears `seq_err` (set wins if same cycle).
- busy  out  1  packet in progress.
- done  out  1  one-cycle pulse after the last byte of a packet is received.
- pkt_cnt  out  16  completed packets, wraps at 2^16.

Behaviour:
- Reset (async on `rst`=1): state IDLE; `ram_rd_rq`=0, `rd_addr`=0, `pl_data`=0, `pl_valid`=0, `pl_idx`=0, `hdr`=0, `hdr_valid`=0, `seq_err`=0, `busy`=0, `done`=0, `pkt_cnt`=0, first-packet flag=1, tag pipeline cleared.
- Reset mid-packet aborts immediately. No partial `done`; no error is flagged.
- FSM states:
  - IDLE: `busy`=0. `start`=1 → ISSUE, with `rd_addr`=0 and `ram_rd_rq`=1 from the next cycle.
  - ISSUE: `ram_rd_rq`=1; `rd_addr` increments by 1 each cycle from 0 to PKT_LEN-1 (exactly PKT_LEN cycles). After PKT_LEN-1 is issued → DRAIN; `ram_rd_rq`=0 and `rd_addr`=0 the following cycle.
  - DRAIN: waits until all outstanding tags return (RD_LATENCY cycles after the last issue) → DONE.
  - DONE: one cycle; `done`=1, `pkt_cnt`+1. Then `cont`=1 → ISSUE (address 0 next cycle), else → IDLE.
- `busy`=1 in ISSUE, DRAIN and DONE.
- `start` is ignored outside IDLE.
- Tag pipeline:
  - Shift register, RD_LATENCY deep, of {valid, addr}.
  - Entry pushed each cycle with valid=`ram_rd_rq`, addr=`rd_addr`.
  - At the tail, valid=1 means `data_i` belongs to that addr.
- Return decoding (tail valid):
  - addr 0: latch `data_i` into `hdr`[15:8].
  - addr 1: latch into `hdr`[7:0], pulse `hdr_valid` the next cycle, run the sequence check.
  - addr ≥ 2: `pl_data`=`data_i`, `pl_valid`=1, `pl_idx`=addr-2, all registered, one cycle after the tail.
- Payload latency: `rd_addr`=k issued at cycle t → payload strobe at t+RD_LATENCY+1.
- Sequence check:
  - First packet after reset: no check; store `hdr` as last header, clear the first-packet flag.
  - Later packets: if `hdr` != last+HDR_STEP (16-bit wrap, 0xFFFF+1=0x0000), set `seq_err`.
  - Last header is updated to `hdr` regardless of the check result.
- `pl_valid` and `hdr_valid` are 0 whenever tail valid=0; no strobes in IDLE.
- Back-to-back packets (`cont`=1):
  - Gap between the last issue of one packet and address 0 of the next = RD_LATENCY+2 cycles (DRAIN + DONE).
  - Tags from different packets never overlap.
- All outputs are registered; no combinational path from `data_i` to outputs.

Test Plan:
- Reset, PKT_LEN=8, RD_LATENCY=2, model slave returns header 0x0005 then bytes 0xA0..0xA5; pulse `start` → `rd_addr` 0..7 with `ram_rd_rq`=1 for 8 cycles; `hdr`=0x0005 with `hdr_valid` pulse; `pl_data` 0xA0..0xA5 at `pl_idx` 0..5; `done` once; `pkt_cnt`=1; `seq_err`=0.
- `cont`=1, slave headers 0x0005, 0x0006, 0x0008 → `seq_err` set at the third packet's `hdr_valid`; `pkt_cnt`=3; gap between packets = 4 cycles.
- Header wrap: consecutive headers 0xFFFF, 0x0000 → `seq_err` stays 0. Then `err_clr` asserted on the same cycle as a new error → `seq_err` remains 1.
- `start` pulsed during ISSUE and DRAIN → ignored; exactly one packet and one `done`.
- Assert `rst` at `rd_addr`=4 → all outputs 0 asynchronously, no `pl_valid`/`done` afterwards. Next `start` is treated as the first packet (no sequence check).
- RD_LATENCY=4 build: `rd_addr`=2 issued at cycle t → `pl_valid` with `pl_idx`=0 at t+5.
